// File: rtl/vc_writeback_buffer_pkg.sv
// Shared types for the victim-cache write-back buffer.
package vc_writeback_buffer_pkg;

  typedef logic [127:0] lc3b_line;
  typedef logic [11:0]  lc3b_line_addr;

  typedef enum logic [1:0] {
    WBB_IDLE  = 2'd0,
    WBB_READ  = 2'd1,
    WBB_WRITE = 2'd2,
    WBB_ACK   = 2'd3
  } wbb_state_t;

endpackage

// File: rtl/wbb_entry_array.sv
// Circular store of queued dirty lines with an address CAM for coalescing
// incoming evictions and for serving L2 reads out of the buffer.
module wbb_entry_array
  import vc_writeback_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int LINE_W = 128
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic [ADDR_W-1:0]       push_addr,
  input  logic [LINE_W-1:0]       push_data,
  input  logic                    pop,
  input  logic                    draining,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic                    wb_hit,
  output logic                    wb_hit_draining,
  output logic                    rd_hit,
  output logic [LINE_W-1:0]       rd_hit_data,
  output logic [ADDR_W-1:0]       head_addr,
  output logic [LINE_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [LINE_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W-1:0]  scan_idx, wb_idx, rd_idx;
  logic              coalesce, alloc;

  // Scan oldest to newest so the newest match wins; a line can only be
  // duplicated as the draining head plus a newer tail copy.
  always_comb begin
    wb_hit   = 1'b0;
    rd_hit   = 1'b0;
    wb_idx   = head;
    rd_idx   = head;
    scan_idx = head;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (valid[scan_idx] && addr_mem[scan_idx] == push_addr) begin
        wb_hit = 1'b1;
        wb_idx = scan_idx;
      end
      if (valid[scan_idx] && addr_mem[scan_idx] == rd_addr) begin
        rd_hit = 1'b1;
        rd_idx = scan_idx;
      end
    end
  end

  assign wb_hit_draining = wb_hit & draining & (wb_idx == head);
  assign coalesce        = wb_hit & ~wb_hit_draining;
  assign alloc           = push & ~coalesce;
  assign rd_hit_data     = data_mem[rd_idx];
  assign head_addr       = addr_mem[head];
  assign head_data       = data_mem[head];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else begin
      if (push && coalesce) begin
        data_mem[wb_idx] <= push_data;
      end else if (alloc) begin
        valid[tail]    <= 1'b1;
        addr_mem[tail] <= push_addr;
        data_mem[tail] <= push_data;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + PTR_W'(1);
      end
      count <= count + CNT_W'(alloc) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/vc_writeback_buffer.sv
// Write-back buffer between the victim cache and pmem: queues dirty lines,
// arbitrates the pmem port between L2 fills and drains, forwards buffered data.
//   state     | meaning
//   WBB_IDLE  | pmem free; pick read-hit ack, miss fill or drain
//   WBB_READ  | pmem read of an L2 miss outstanding
//   WBB_WRITE | head line being written to pmem
//   WBB_ACK   | rd_ack pulse with rd_data
module vc_writeback_buffer
  import vc_writeback_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [LINE_W-1:0] wb_data,
  output logic              wb_accept,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_address,
  output logic [LINE_W-1:0] rd_data,
  output logic              rd_ack,
  output logic              pmem_busy,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [15:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wbb_state_t        state, state_next;
  logic [ADDR_W-1:0] rd_addr_q, head_addr;
  logic [LINE_W-1:0] rd_data_q, rd_hit_data, head_data;
  logic [CNT_W-1:0]  count;
  logic              wb_hit, wb_hit_draining, rd_hit;
  logic              full, push, pop, fwd, rd_any_hit;

  wbb_entry_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_entry_array (
    .clk             (clk),
    .reset_n         (reset_n),
    .push            (push),
    .push_addr       (wb_address),
    .push_data       (wb_data),
    .pop             (pop),
    .draining        (state == WBB_WRITE),
    .rd_addr         (rd_address),
    .wb_hit          (wb_hit),
    .wb_hit_draining (wb_hit_draining),
    .rd_hit          (rd_hit),
    .rd_hit_data     (rd_hit_data),
    .head_addr       (head_addr),
    .head_data       (head_data),
    .count           (count)
  );

  assign full       = (count == CNT_W'(DEPTH));
  assign push       = reset_n & wb_valid & (~full | (wb_hit & ~wb_hit_draining));
  assign pop        = (state == WBB_WRITE) & pmem_resp;
  assign fwd        = push & (wb_address == rd_address);
  assign rd_any_hit = rd_hit | fwd;

  // A full buffer drains before any miss fill is allowed to start.
  always_comb begin
    state_next = state;
    case (state)
      WBB_IDLE: begin
        if (rd_req && rd_any_hit)  state_next = WBB_ACK;
        else if (rd_req && !full)  state_next = WBB_READ;
        else if (count != '0)      state_next = WBB_WRITE;
      end
      WBB_READ:  if (pmem_resp) state_next = WBB_ACK;
      WBB_WRITE: if (pmem_resp) state_next = WBB_IDLE;
      WBB_ACK:   state_next = WBB_IDLE;
      default:   state_next = WBB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= WBB_IDLE;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      state <= state_next;
      if (state == WBB_IDLE && rd_req) begin
        rd_addr_q <= rd_address;
        if (fwd)         rd_data_q <= wb_data;
        else if (rd_hit) rd_data_q <= rd_hit_data;
      end
      if (state == WBB_READ && pmem_resp) rd_data_q <= pmem_rdata;
    end
  end

  always_comb begin
    pmem_address = '0;
    pmem_wdata   = '0;
    if (state == WBB_READ) begin
      pmem_address = 16'({rd_addr_q, 4'b0000});
    end else if (state == WBB_WRITE) begin
      pmem_address = 16'({head_addr, 4'b0000});
      pmem_wdata   = head_data;
    end
  end

  assign wb_accept  = push;
  assign rd_data    = rd_data_q;
  assign rd_ack     = (state == WBB_ACK);
  assign pmem_busy  = (state != WBB_IDLE);
  assign pmem_read  = (state == WBB_READ);
  assign pmem_write = (state == WBB_WRITE);

endmodule

// File: tb/tb_vc_writeback_buffer.sv
// Directed bench for vc_writeback_buffer: the bench plays victim cache, L2 and pmem.
module tb_vc_writeback_buffer;
  import vc_writeback_buffer_pkg::*;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          wb_valid;
  lc3b_line_addr wb_address;
  lc3b_line      wb_data;
  logic          wb_accept;
  logic          rd_req;
  lc3b_line_addr rd_address;
  lc3b_line      rd_data;
  logic          rd_ack;
  logic          pmem_busy;
  logic          pmem_read;
  logic          pmem_write;
  logic [15:0]   pmem_address;
  lc3b_line      pmem_wdata;
  lc3b_line      pmem_rdata;
  logic          pmem_resp;

  int n_checks = 0;
  int n_errors = 0;
  int rd_cycles = 0;
  int wr_starts = 0;
  logic wr_prev = 1'b0;

  vc_writeback_buffer #(.DEPTH(4), .ADDR_W(12), .LINE_W(128)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wb_valid     (wb_valid),
    .wb_address   (wb_address),
    .wb_data      (wb_data),
    .wb_accept    (wb_accept),
    .rd_req       (rd_req),
    .rd_address   (rd_address),
    .rd_data      (rd_data),
    .rd_ack       (rd_ack),
    .pmem_busy    (pmem_busy),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pmem_read) rd_cycles++;
    if (pmem_write && !wr_prev) wr_starts++;
    wr_prev = pmem_write;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] req);
    n_checks++;
    if (obs !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, req);
    end
  endtask

  function automatic lc3b_line pat(input logic [15:0] s);
    return {8{s}};
  endfunction

  // Present a line and hold it until accepted; returns on the negedge after the accept edge.
  task automatic push(input lc3b_line_addr a, input lc3b_line d);
    int n = 0;
    wb_valid = 1'b1; wb_address = a; wb_data = d;
    #1;
    while (!wb_accept && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("wb_accept", wb_accept, 1);
    @(negedge clk);
    wb_valid = 1'b0;
  endtask

  task automatic serve_write(input logic [15:0] addr, input lc3b_line d, input int delay);
    int n = 0;
    while (!pmem_write && n < 100) begin
      @(negedge clk); n++;
    end
    check("wr_strobe", pmem_write, 1);
    check("wr_addr", pmem_address, addr);
    check("wr_data", pmem_wdata, d);
    repeat (delay) @(negedge clk);
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("wr_release", pmem_write, 0);
  endtask

  // Returns on the negedge where rd_ack should be high; rd_req is left to the caller.
  task automatic serve_read(input logic [15:0] addr, input lc3b_line d, input int delay);
    int n = 0;
    while (!pmem_read && n < 100) begin
      @(negedge clk); n++;
    end
    check("rd_strobe", pmem_read, 1);
    check("rd_addr", pmem_address, addr);
    repeat (delay) @(negedge clk);
    check("rd_hold", pmem_read, 1);
    pmem_rdata = d; pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0;
    check("rd_ack", rd_ack, 1);
    check("rd_data", rd_data, d);
    check("rd_release", pmem_read, 0);
  endtask

  initial begin
    int w0, r0;
    reset_n = 1'b0; wb_valid = 1'b0; wb_address = '0; wb_data = '0;
    rd_req = 1'b0; rd_address = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_accept", wb_accept, 0);
    check("rst_ack", rd_ack, 0);
    check("rst_rdata", rd_data, 0);
    check("rst_busy", pmem_busy, 0);
    check("rst_read", pmem_read, 0);
    check("rst_write", pmem_write, 0);
    check("rst_paddr", pmem_address, 0);
    check("rst_wdata", pmem_wdata, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // reset in the middle of a drain
    push(12'h050, pat(16'h5050));
    push(12'h051, pat(16'h5151));
    check("t1_writing", pmem_write, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check("t1_write_off", pmem_write, 0);
    check("t1_busy_off", pmem_busy, 0);
    check("t1_paddr", pmem_address, 0);
    check("t1_wdata", pmem_wdata, 0);
    check("t1_ack", rd_ack, 0);
    @(negedge clk);
    reset_n = 1'b1;
    w0 = wr_starts;
    repeat (10) @(negedge clk);
    check("t1_discarded", wr_starts - w0, 0);
    check("t1_idle", pmem_busy, 0);

    // fill to DEPTH, fifth eviction held until the first drain completes
    push(12'h100, pat(16'h1000));
    push(12'h101, pat(16'h1010));
    push(12'h102, pat(16'h1020));
    push(12'h103, pat(16'h1030));
    wb_valid = 1'b1; wb_address = 12'h104; wb_data = pat(16'h1040);
    #1;
    check("t2_full_hold0", wb_accept, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("t2_full_hold", wb_accept, 0);
    end
    serve_write(16'h1000, pat(16'h1000), 0);
    #1;
    check("t2_accept_after_pop", wb_accept, 1);
    @(negedge clk);
    wb_valid = 1'b0;
    serve_write(16'h1010, pat(16'h1010), 1);
    serve_write(16'h1020, pat(16'h1020), 0);
    serve_write(16'h1030, pat(16'h1030), 2);
    serve_write(16'h1040, pat(16'h1040), 0);

    // coalesce while pmem is busy with a fill
    rd_req = 1'b1; rd_address = 12'h0E0;
    @(negedge clk);
    push(12'h0A0, pat(16'hD1D1));
    push(12'h0A0, pat(16'hD2D2));
    w0 = wr_starts;
    serve_read(16'h0E00, pat(16'hE0E0), 3);
    rd_req = 1'b0;
    serve_write(16'h0A00, pat(16'hD2D2), 0);
    repeat (10) @(negedge clk);
    check("t3_single_write", wr_starts - w0, 1);

    // read hit by same-cycle forwarding, then from a queued entry
    r0 = rd_cycles;
    wb_valid = 1'b1; wb_address = 12'h0B0; wb_data = pat(16'hD3D3);
    rd_req = 1'b1; rd_address = 12'h0B0;
    #1;
    check("t4_fwd_accept", wb_accept, 1);
    @(negedge clk);
    check("t4_fwd_ack", rd_ack, 1);
    check("t4_fwd_data", rd_data, pat(16'hD3D3));
    wb_valid = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("t4_ack_pulse", rd_ack, 0);
    serve_write(16'h0B00, pat(16'hD3D3), 0);
    push(12'h0B1, pat(16'hD5D5));
    push(12'h0B2, pat(16'hD6D6));
    rd_req = 1'b1; rd_address = 12'h0B2;
    serve_write(16'h0B10, pat(16'hD5D5), 1);
    @(negedge clk);
    check("t4_hit_ack", rd_ack, 1);
    check("t4_hit_data", rd_data, pat(16'hD6D6));
    rd_req = 1'b0;
    check("t4_no_pmem_read", rd_cycles - r0, 0);
    serve_write(16'h0B20, pat(16'hD6D6), 0);

    // miss with slow pmem, push during READ waits for ACK->IDLE
    rd_req = 1'b1; rd_address = 12'h0C0;
    @(negedge clk);
    push(12'h0C5, pat(16'hC5C5));
    w0 = wr_starts;
    serve_read(16'h0C00, pat(16'hD4D4), 5);
    check("t5_no_write_in_ack", pmem_write, 0);
    check("t5_no_early_drain", wr_starts - w0, 0);
    rd_req = 1'b0;
    @(negedge clk);
    check("t5_idle_gap", pmem_write, 0);
    serve_write(16'h0C50, pat(16'hC5C5), 0);

    // full buffer in IDLE: drain one line before the miss read
    rd_req = 1'b1; rd_address = 12'h0E1;
    @(negedge clk);
    push(12'h061, pat(16'h6161));
    push(12'h062, pat(16'h6262));
    push(12'h063, pat(16'h6363));
    push(12'h064, pat(16'h6464));
    serve_read(16'h0E10, pat(16'hE1E1), 0);
    rd_address = 12'h0D0;
    r0 = rd_cycles;
    serve_write(16'h0610, pat(16'h6161), 0);
    check("t6_drain_first", rd_cycles - r0, 0);
    serve_read(16'h0D00, pat(16'hD7D7), 2);
    rd_req = 1'b0;
    serve_write(16'h0620, pat(16'h6262), 0);
    serve_write(16'h0630, pat(16'h6363), 0);
    serve_write(16'h0640, pat(16'h6464), 0);
    repeat (3) @(negedge clk);
    check("t6_idle_end", pmem_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
